uart_byte_rx: RTL and testbench
===============================

Name: uart_byte_rx

Overview:
- Standalone 8N1 UART receiver; the receiving end of the `uart_0_txd` serial link driven by the Nios system.
- Lets fabric logic (command decoders, LED/key test logic) take bytes from the soft-core without a bus master.
- Samples the asynchronous serial line in the `clk50m` domain.
- Delivers each byte through a one-entry valid/ready buffer, with framing and overrun flags.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (integer division; 434 at defaults), required >= 4.
- SYNC_STAGES, 2, number of flops in the rxd synchronizer (>= 2).

Ports:
- clk50m  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- uart_rxd  in  1  serial input, idle high, asynchronous to clk50m.
- rx_data  out  8  received byte, LSB first on the line.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts byte when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low (or parity error, see below).
- overrun  out  1  sticky: byte completed while buffer still full; cleared by reset or by a handshake.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, reset_n low):
  - synchronizer flops preset to 1;
  - state = IDLE, counters = 0;
  - rx_data = 8'h00; rx_valid, frame_err, overrun, rx_busy = 0.
- Input: uart_rxd passes through SYNC_STAGES flops; only the synchronized value (rxs) is used.
- Baud counter: counts 0..BAUD_DIV-1; reloads to 0 on every state entry.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on rxs falling (previous 1, current 0) go to START.
  - START: wait BAUD_DIV/2 cycles, then sample rxs.
    - 0: go to DATA with bit index 0.
    - 1: glitch; return to IDLE with no flag.
  - DATA: every BAUD_DIV cycles sample rxs into shift register bit[index], LSB first. After index 7, go to STOP (or PARITY when the optional feature is enabled).
  - STOP: after BAUD_DIV cycles sample rxs.
    - 1: frame complete; return to IDLE.
    - 0: frame_err pulse; byte discarded; go to BREAK.
  - BREAK: wait until rxs = 1, then go to IDLE. No new frame is detected while the line is held low.
- Output buffer:
  - On a good frame with rx_valid = 0: rx_data <= shift register and rx_valid <= 1, one cycle after the stop sample.
  - On a good frame with rx_valid = 1 and no handshake in the same cycle: new byte dropped, rx_data unchanged, overrun <= 1.
  - Good frame in the same cycle as a handshake: new byte loaded, rx_valid stays 1, no overrun.
  - Handshake (rx_valid && rx_ready): rx_valid <= 0 and overrun <= 0 unless a new byte loads in the same cycle.
- rx_data stable while rx_valid = 1.
- Latency: falling start edge at rxd pin to rx_valid = SYNC_STAGES + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles (±1).
- The next start bit is accepted in the cycle after returning to IDLE, so back-to-back frames with a 1-bit stop are received.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - frame becomes 8E1;
  - PARITY state inserted between DATA and STOP, sampled BAUD_DIV cycles after bit 7;
  - parity mismatch (XOR of 8 data bits and parity bit != 0) marks the frame bad;
  - after a good stop bit, a bad frame gives a frame_err pulse instead of loading the buffer; return to IDLE, not BREAK;
  - latency grows by BAUD_DIV.
- Undefined: 8N1, no PARITY state.

Test Plan (CLK_FREQ=1000000, BAUD=100000, so BAUD_DIV=10; parity disabled unless stated):
1. Send 8'hA5 with rx_ready=1 → rx_valid high 1 cycle, rx_data=8'hA5, frame_err=0, overrun=0.
2. Send 8'h3C then 8'hC3 back-to-back, rx_ready=0 → rx_data stays 8'h3C, rx_valid=1, overrun=1 after the second stop. Then assert rx_ready 1 cycle → rx_valid=0, overrun=0.
3. 3-cycle low glitch on idle uart_rxd → FSM back to IDLE, no rx_valid, no frame_err.
4. Send 8'h55 with the stop bit forced low, then hold the line low 50 cycles, then release → one frame_err pulse, no rx_valid, rx_busy high until release. A following 8'h12 is received correctly.
5. Assert reset_n low mid-DATA of 8'hFF, release, send 8'h01 → all outputs 0 during reset; only 8'h01 delivered.
6. With UART_RX_PARITY_EN: send 8'h07 with parity 1 → rx_data=8'h07. Send 8'h07 with parity 0 → frame_err pulse, rx_valid stays 0.

Source files
------------

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with a one-entry valid/ready output buffer.
// Define UART_RX_PARITY_EN to receive 8E1 frames and flag parity errors via frame_err.
module uart_byte_rx #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk50m,
    input  logic       reset_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP, BREAK
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic perr_q, perr_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic prev_q;
    logic [7:0] rx_data_q;
    logic rx_valid_q, frame_err_q, overrun_q;
    logic rxs, good, bad, hs, load;

    assign rxs = sync_q[SYNC_STAGES-1];
    assign hs = rx_valid_q && rx_ready;
    assign load = good && (!rx_valid_q || hs);

    always_comb begin
        state_d = state_q;
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        shift_d = shift_q;
        perr_d = perr_q;
        good = 1'b0;
        bad = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (prev_q && !rxs) state_d = START;
            end
            START: if (cnt_q == HALF_LAST) begin
                cnt_d = '0;
                idx_d = '0;
                state_d = rxs ? IDLE : DATA;
            end
            DATA: if (cnt_q == LAST) begin
                shift_d[idx_q] = rxs;
                idx_d = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                if (idx_q == 3'd7) state_d = PARITY;
`else
                if (idx_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt_q == LAST) begin
                perr_d = ^{shift_q, rxs};
                state_d = STOP;
            end
`endif
            STOP: if (cnt_q == LAST) begin
                // A low stop bit means the line may be in a break; wait it out before re-arming.
                good = rxs && !perr_q;
                bad = !rxs || perr_q;
                state_d = rxs ? IDLE : BREAK;
            end
            BREAK: begin
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            state_q <= IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            shift_q <= '0;
            perr_q <= 1'b0;
            rx_data_q <= '0;
            rx_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
            prev_q <= rxs;
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            shift_q <= shift_d;
            perr_q <= perr_d;
            if (load) rx_data_q <= shift_q;
            rx_valid_q <= load || (rx_valid_q && !hs);
            frame_err_q <= bad;
            overrun_q <= (good && rx_valid_q && !hs) || (overrun_q && !(hs && !load));
        end
    end

    assign rx_data = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun = overrun_q;
    assign rx_busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed table-driven bench for uart_byte_rx at BAUD_DIV = 10.
module tb_uart_byte_rx;
    logic clk50m = 1'b0;
    logic reset_n = 1'b0;
    logic uart_rxd = 1'b1;
    logic rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic rx_valid, frame_err, overrun, rx_busy;

    int tests = 0, fails = 0, cyc = 0;
    int nvalid = 0, nvcyc = 0, nferr = 0, t_start = 0, t_valid = 0;
    logic [7:0] last_data = 8'h00;
    logic pv = 1'b0;

`ifdef UART_RX_PARITY_EN
    localparam int LAT = 108;
`else
    localparam int LAT = 98;
`endif

    typedef struct {
        logic [7:0] d;
        logic stop;
        int exp_nv;
        int exp_fe;
    } vec_t;
    vec_t v[7];

    uart_byte_rx #(.CLK_FREQ(1000000), .BAUD(100000), .SYNC_STAGES(2)) dut (
        .clk50m(clk50m), .reset_n(reset_n), .uart_rxd(uart_rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
    );

    always #5 clk50m = ~clk50m;
    always @(posedge clk50m) cyc++;

    always @(negedge clk50m) begin
        if (rx_valid && !pv) begin
            nvalid++;
            last_data = rx_data;
            t_valid = cyc;
        end
        if (rx_valid) nvcyc++;
        if (frame_err) nferr++;
        pv = rx_valid;
    end

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic hold(input logic b, input int n);
        uart_rxd = b;
        repeat (n) begin
            @(posedge clk50m);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        t_start = cyc;
        hold(1'b0, 10);
        for (int i = 0; i < 8; i++) hold(d[i], 10);
`ifdef UART_RX_PARITY_EN
        hold(^d, 10);
`endif
        hold(stop, 10);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par(input logic [7:0] d, input logic p);
        hold(1'b0, 10);
        for (int i = 0; i < 8; i++) hold(d[i], 10);
        hold(p, 10);
        hold(1'b1, 10);
    endtask
`endif

    initial begin
        int nv0, fe0, vc0, lat;
        v[0] = '{8'hA5, 1'b1, 1, 0};
        v[1] = '{8'h00, 1'b1, 1, 0};
        v[2] = '{8'hFF, 1'b1, 1, 0};
        v[3] = '{8'h81, 1'b1, 1, 0};
        v[4] = '{8'h5A, 1'b1, 1, 0};
        v[5] = '{8'h55, 1'b0, 0, 1};
        v[6] = '{8'h12, 1'b1, 1, 0};

        repeat (3) @(posedge clk50m);
        #1;
        chk("reset rx_data", rx_data, 0);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overrun", overrun, 0);
        chk("reset rx_busy", rx_busy, 0);
        reset_n = 1'b1;
        rx_ready = 1'b1;
        hold(1'b1, 5);

        for (int i = 0; i < 7; i++) begin
            nv0 = nvalid; fe0 = nferr; vc0 = nvcyc;
            send(v[i].d, v[i].stop);
            hold(1'b1, 5);
            chk($sformatf("vec%0d valid count", i), nvalid - nv0, v[i].exp_nv);
            chk($sformatf("vec%0d valid cycles", i), nvcyc - vc0, v[i].exp_nv);
            chk($sformatf("vec%0d frame_err", i), nferr - fe0, v[i].exp_fe);
            if (v[i].exp_nv != 0) chk($sformatf("vec%0d data", i), last_data, v[i].d);
            chk($sformatf("vec%0d overrun", i), overrun, 0);
            chk($sformatf("vec%0d busy", i), rx_busy, 0);
            if (i == 0) begin
                lat = t_valid - t_start;
                chk("latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
            end
        end

        rx_ready = 1'b0;
        nv0 = nvalid;
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b1);
        hold(1'b1, 5);
        chk("ovr valid", rx_valid, 1);
        chk("ovr data kept", rx_data, 8'h3C);
        chk("ovr flag", overrun, 1);
        chk("ovr valid count", nvalid - nv0, 1);
        rx_ready = 1'b1;
        @(posedge clk50m);
        #1;
        rx_ready = 1'b0;
        chk("ovr hs valid", rx_valid, 0);
        chk("ovr hs overrun", overrun, 0);
        rx_ready = 1'b1;

        nv0 = nvalid; fe0 = nferr;
        hold(1'b0, 3);
        hold(1'b1, 20);
        chk("glitch valid", nvalid - nv0, 0);
        chk("glitch frame_err", nferr - fe0, 0);
        chk("glitch busy", rx_busy, 0);

        nv0 = nvalid; fe0 = nferr;
        send(8'h55, 1'b0);
        hold(1'b0, 50);
        chk("break busy", rx_busy, 1);
        hold(1'b1, 5);
        chk("break released busy", rx_busy, 0);
        chk("break frame_err", nferr - fe0, 1);
        chk("break valid", nvalid - nv0, 0);
        nv0 = nvalid;
        send(8'h12, 1'b1);
        hold(1'b1, 5);
        chk("after break count", nvalid - nv0, 1);
        chk("after break data", last_data, 8'h12);

        nv0 = nvalid;
        hold(1'b0, 10);
        hold(1'b1, 35);
        reset_n = 1'b0;
        #2;
        chk("midrst busy", rx_busy, 0);
        chk("midrst data", rx_data, 0);
        chk("midrst valid", rx_valid, 0);
        chk("midrst overrun", overrun, 0);
        chk("midrst frame_err", frame_err, 0);
        hold(1'b1, 3);
        reset_n = 1'b1;
        hold(1'b1, 5);
        send(8'h01, 1'b1);
        hold(1'b1, 5);
        chk("post rst count", nvalid - nv0, 1);
        chk("post rst data", last_data, 8'h01);

`ifdef UART_RX_PARITY_EN
        nv0 = nvalid; fe0 = nferr;
        send_par(8'h07, 1'b1);
        hold(1'b1, 5);
        chk("par good count", nvalid - nv0, 1);
        chk("par good data", last_data, 8'h07);
        chk("par good frame_err", nferr - fe0, 0);
        nv0 = nvalid; fe0 = nferr;
        send_par(8'h07, 1'b0);
        hold(1'b1, 5);
        chk("par bad count", nvalid - nv0, 0);
        chk("par bad frame_err", nferr - fe0, 1);
        chk("par bad valid", rx_valid, 0);
        chk("par bad busy", rx_busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
